qerv_rf_ram_1p_bridge: RTL and testbench

Adapter between the register-file RAM interface and a single-port SRAM macro. It takes the interface's independent read and write strobes and presents one access per cycle to the SRAM. Reads always win the port. Writes that collide with a read are parked in a small write buffer and drained on idle cycles. Reads that hit a parked write are forwarded from the buffer, so the upstream side sees true dual-port semantics.

---
 rtl/qerv_rf_ram_1p_bridge.sv | 108 ++++++++++
 tb/tb_qerv_rf_ram_1p_bridge.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/qerv_rf_ram_1p_bridge.sv
// qerv_rf_ram_1p_bridge: dual-port RF RAM view over a single-port SRAM, reads win and colliding writes park in a FIFO.
// Define QERV_RF_1P_COALESCE_EN to merge writes into a matching buffered entry in place.
module qerv_rf_ram_1p_bridge #(
    parameter int width = 8,
    parameter int aw    = 8,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [aw-1:0]    i_waddr,
    input  logic [width-1:0] i_wdata,
    input  logic             i_wen,
    input  logic [aw-1:0]    i_raddr,
    input  logic             i_ren,
    output logic [width-1:0] o_rdata,
    output logic [aw-1:0]    o_sram_addr,
    output logic [width-1:0] o_sram_wdata,
    output logic             o_sram_we,
    output logic             o_sram_en,
    input  logic [width-1:0] i_sram_rdata,
    output logic             o_overflow,
    output logic             o_idle
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [aw-1:0]    buf_addr [DEPTH];
    logic [width-1:0] buf_data [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr, idx;
    logic [CW-1:0]    count;
    logic             fwd_hit_r, overflow_r, hit, coal;
    logic [width-1:0] fwd_data_r, hit_data;
    logic             empty, full, pop, direct, push, drop;
`ifdef QERV_RF_1P_COALESCE_EN
    logic [PW-1:0]    coal_idx;
`endif

    assign empty  = count == '0;
    assign full   = count == CW'(DEPTH);
    assign pop    = !i_rst && !i_ren && !empty;
    assign direct = !i_ren && empty && i_wen;

    // Scan oldest to newest so the newest matching entry is the one kept.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        idx      = '0;
        coal     = 1'b0;
`ifdef QERV_RF_1P_COALESCE_EN
        coal_idx = '0;
`endif
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PW'(k);
            if (CW'(k) < count && buf_addr[idx] == i_raddr) begin
                hit      = 1'b1;
                hit_data = buf_data[idx];
            end
`ifdef QERV_RF_1P_COALESCE_EN
            if (i_wen && !direct && CW'(k) < count && !(pop && k == 0) && buf_addr[idx] == i_waddr) begin
                coal     = 1'b1;
                coal_idx = idx;
            end
`endif
        end
    end

    assign push = i_wen && !direct && !coal && (!full || pop);
    assign drop = i_wen && !direct && !coal && full && !pop;

    assign o_sram_en    = !i_rst && (i_ren || !empty || i_wen);
    assign o_sram_we    = !i_rst && !i_ren && (!empty || i_wen);
    assign o_sram_addr  = i_rst ? '0 : i_ren ? i_raddr : !empty ? buf_addr[rd_ptr] : i_wen ? i_waddr : '0;
    assign o_sram_wdata = (i_rst || i_ren) ? '0 : !empty ? buf_data[rd_ptr] : i_wen ? i_wdata : '0;
    assign o_rdata      = fwd_hit_r ? fwd_data_r : i_sram_rdata;
    assign o_overflow   = overflow_r;
    assign o_idle       = empty;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            fwd_hit_r  <= 1'b0;
            fwd_data_r <= '0;
            overflow_r <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count      <= count + CW'(push) - CW'(pop);
            fwd_hit_r  <= i_ren && hit;
            fwd_data_r <= i_ren ? hit_data : '0;
            overflow_r <= overflow_r || drop;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            buf_addr[wr_ptr] <= i_waddr;
            buf_data[wr_ptr] <= i_wdata;
        end
`ifdef QERV_RF_1P_COALESCE_EN
        if (coal)
            buf_data[coal_idx] <= i_wdata;
`endif
    end
endmodule

// File: tb/tb_qerv_rf_ram_1p_bridge.sv
// tb_qerv_rf_ram_1p_bridge: scoreboard bench against a queue-based model of the bridge and a behavioural SRAM.
module tb_qerv_rf_ram_1p_bridge;
    localparam int D = 4;
`ifdef QERV_RF_1P_COALESCE_EN
    localparam bit COAL = 1'b1;
`else
    localparam bit COAL = 1'b0;
`endif

    logic       clk = 1'b0, rst = 1'b0;
    logic [7:0] waddr = '0, wdata = '0, raddr = '0;
    logic       wen = 1'b0, ren = 1'b0;
    logic [7:0] rdata, sram_addr, sram_wdata, sram_rdata = '0;
    logic       sram_we, sram_en, overflow, idle;

    qerv_rf_ram_1p_bridge #(.width(8), .aw(8), .DEPTH(D)) dut (
        .i_clk(clk), .i_rst(rst), .i_waddr(waddr), .i_wdata(wdata), .i_wen(wen),
        .i_raddr(raddr), .i_ren(ren), .o_rdata(rdata), .o_sram_addr(sram_addr),
        .o_sram_wdata(sram_wdata), .o_sram_we(sram_we), .o_sram_en(sram_en),
        .i_sram_rdata(sram_rdata), .o_overflow(overflow), .o_idle(idle)
    );

    always #5 clk = ~clk;

    bit [7:0] mem [256];
    always @(posedge clk)
        if (sram_en) begin
            if (sram_we) mem[sram_addr] <= sram_wdata;
            else sram_rdata <= mem[sram_addr];
        end

    typedef struct { logic [7:0] a; logic [7:0] d; } ent_t;
    ent_t       q[$];
    logic [7:0] exp_rd[$];
    bit [7:0]   ref_mem [256];
    bit         exp_ovf = 1'b0, rd_pend = 1'b0;
    int         checks = 0, errors = 0;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", n, act, exp, $time);
        end
    endtask

    always @(posedge clk) rd_pend <= !rst && ren;

    always @(negedge clk)
        if (rd_pend) begin
            if (exp_rd.size() == 0) chk("rdata_unexpected", 1, 0);
            else chk("rdata", rdata, exp_rd.pop_front());
        end

    // One upstream cycle: predict the SRAM access, score the read, then advance the queue model.
    task automatic cyc(input bit we_, input logic [7:0] wa, input logic [7:0] wd, input bit re, input logic [7:0] ra);
        bit e_en, e_we, coal_done, dropped;
        logic [7:0] e_a, e_d;
        wen = we_; waddr = wa; wdata = wd; ren = re; raddr = ra;
        #1;
        e_en = re || q.size() > 0 || we_;
        e_we = !re && (q.size() > 0 || we_);
        e_a  = re ? ra : q.size() > 0 ? q[0].a : we_ ? wa : 8'h00;
        e_d  = q.size() > 0 ? q[0].d : wd;
        chk("sram_en", sram_en, e_en);
        chk("sram_we", sram_we, e_we);
        if (e_en) chk("sram_addr", sram_addr, e_a);
        if (e_we) chk("sram_wdata", sram_wdata, e_d);
        if (re) exp_rd.push_back(ref_mem[ra]);
        coal_done = 1'b0;
        dropped = 1'b0;
        if (re || q.size() > 0) begin
            if (we_ && COAL)
                for (int i = (re ? 0 : 1); i < q.size(); i++)
                    if (q[i].a == wa) begin q[i].d = wd; coal_done = 1'b1; end
            if (!re) void'(q.pop_front());
            if (we_ && !coal_done) begin
                if (q.size() == D) begin dropped = 1'b1; exp_ovf = 1'b1; end
                else q.push_back('{wa, wd});
            end
        end
        if (we_ && !dropped) ref_mem[wa] = wd;
        @(posedge clk);
        #1;
        chk("idle", idle, q.size() == 0);
        chk("overflow", overflow, exp_ovf);
    endtask

    task automatic idle_cyc();
        cyc(1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
    endtask

    task automatic reset_dut();
        rst = 1'b1; wen = 1'b0; ren = 1'b0; waddr = '0; wdata = '0; raddr = '0;
        #1;
        chk("rst_sram_en", sram_en, 0);
        chk("rst_sram_we", sram_we, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        exp_ovf = 1'b0;
        for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
        #1;
        chk("rst_idle", idle, 1);
        chk("rst_overflow", overflow, 0);
        chk("rst_sram_addr", sram_addr, 0);
        chk("rst_sram_wdata", sram_wdata, 0);
        chk("rst_rdata_follows", rdata, sram_rdata);
    endtask

    initial begin
        @(posedge clk);
        #1;
        reset_dut();
        cyc(1, 8'h10, 8'hA5, 0, 8'h00);
        cyc(0, 8'h00, 8'h00, 1, 8'h10);
        cyc(1, 8'h21, 8'h3C, 1, 8'h20);
        cyc(0, 8'h00, 8'h00, 1, 8'h21);
        idle_cyc();
        cyc(1, 8'h05, 8'h11, 0, 8'h00);
        cyc(1, 8'h05, 8'h22, 1, 8'h05);
        cyc(0, 8'h00, 8'h00, 1, 8'h05);
        idle_cyc();
        cyc(1, 8'h07, 8'h01, 1, 8'h00);
        cyc(1, 8'h07, 8'h02, 1, 8'h00);
        cyc(0, 8'h00, 8'h00, 1, 8'h07);
        repeat (3) idle_cyc();
        cyc(0, 8'h00, 8'h00, 1, 8'h07);
        for (int i = 0; i < 5; i++) cyc(1, 8'h40 + 8'(i), 8'h90 + 8'(i), 1, 8'h80);
        chk("overflow_sticky", overflow, 1);
        repeat (5) idle_cyc();
        cyc(0, 8'h00, 8'h00, 1, 8'h44);
        for (int i = 0; i < 3; i++) cyc(1, 8'h50 + 8'(i), 8'h60 + 8'(i), 1, 8'h00);
        reset_dut();
        idle_cyc();
        cyc(0, 8'h00, 8'h00, 1, 8'h50);
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 99) == 0) reset_dut();
            else cyc($urandom_range(0, 9) < 6, 8'($urandom_range(0, 15)), 8'($urandom),
                     $urandom_range(0, 9) < 6, 8'($urandom_range(0, 15)));
        end
        repeat (6) idle_cyc();
        chk("scoreboard_drained", exp_rd.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
